alu_issue: RTL and testbench
============================

# alu_issue

Decode-and-issue stage feeding the 4-bit ALU `Func` interface. It decodes a 32-bit MIPS instruction and registers the ALU control word, operand-select, extended immediate, and writeback and memory controls into the ID/EX boundary. It also owns a 32-cycle iterative multiplier with HI/LO registers for mult/multu/mfhi/mflo, and raises a stall while a multiply result is pending. It sits between instruction fetch and the ALU; outputs change on posedge, and the ALU samples them on the following negedge.

## Interface
- No parameters; widths fixed at 32-bit datapath, 5-bit register index.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `id_valid` in 1: `id_instr` holds a real instruction.
- `id_instr` in 32: instruction word.
- `rs_val` in 32: rs operand, used only by mult/multu.
- `rt_val` in 32: rt operand, used only by mult/multu.
- `ex_stall` in 1: downstream hazard; hold ID/EX contents.
- `flush` in 1: kill the instruction entering ID/EX.
- `id_stall` out 1: ID must hold `id_instr` this cycle.
- `ex_valid` out 1: ID/EX holds a live instruction.
- `ex_func` out 4: ALU `Func` code.
- `ex_imm_sel` out 1: ALU `In2` takes `ex_imm`, not the register value.
- `ex_imm` out 32: extended immediate, or HI/LO value for mfhi/mflo.
- `ex_reg_write` out 1: write `ex_wr_reg`.
- `ex_wr_reg` out 5: destination register.
- `ex_mem_read` out 1: lw.
- `ex_mem_write` out 1: sw.
- `ex_branch` out 2: 01 beq, 10 bne, 11 j, 00 none.
- `ex_illegal` out 1: undecodable instruction issued as a bubble.
- `mul_busy` out 1: multiplier running.

## Operation
**Func mapping**
- and/andi → 0000.
- or/ori → 0001.
- add/addu/addi/addiu/lw/sw → 0010.
- xor/xori → 0011.
- lui/mfhi/mflo → 0101 (pass `In2`).
- sub/subu/beq/bne → 1010.
- slt/sltu/slti/sltiu → 1111 (invert-and-add, sign bit). Unsigned compare is not distinguished; this is a known limitation.
- j → 0010 (don't-care).

**Immediate extension**
- andi/ori/xori: zero-extend.
- lui: {imm16, 16'h0}.
- All other I-type: sign-extend.
- mfhi/mflo: `ex_imm` = HI/LO, `ex_imm_sel`=1.

**Register write**
- Destination: R-type writes rd; I-type ALU ops and lw write rt.
- sw, branches, j, mult and multu do not write.

**Legal instructions**
- R-type funct: 0x20–0x25, 0x26, 0x2A, 0x2B, 0x18, 0x19, 0x10, 0x12.
- Opcodes: 0x02, 0x04, 0x05, 0x08–0x0F, 0x23, 0x2B.
- Anything else → `ex_illegal`=1, `ex_valid`=0, all enables 0.

**ID/EX register update priority**
1. `!rst_n`: all zero.
2. `flush`: bubble.
3. `ex_stall`: hold.
4. `id_stall`: bubble.
5. Otherwise load the decoded instruction.
- A bubble has `ex_valid`=0, all enables 0, `ex_func`=0000, `ex_illegal`=0.

**Multiplier FSM (IDLE, RUN)**
- IDLE → RUN when mult/multu is loaded into ID/EX. Capture `rs_val`/`rt_val`; for mult, store magnitudes plus a result-sign bit. Clear the 6-bit counter.
- mult/multu itself enters EX as `ex_valid`=1 with all enables 0.
- RUN: one shift-add step per cycle, 64-bit accumulator.
- On step 32, write {HI,LO], applying two's-complement negation if the sign bit is set, then return to IDLE.
- `mul_busy` = (state==RUN).
- `id_stall` = `id_valid` & `mul_busy` & (mult | multu | mfhi | mflo).
- `flush` and `ex_stall` do not abort RUN. A multiply that has been accepted always completes.
- HI/LO reset to 0.

## Timing
- Decode latency: 1 cycle, instruction at ID on edge N appears on `ex_*` after edge N.
- Multiply acceptance: mult accepted at edge N → `mul_busy`=1 after edge N through edge N+31.
- Multiply completion: HI/LO updated and `mul_busy`=0 at edge N+32.
- mfhi/mflo ordering: an mfhi/mflo waiting in ID loads at edge N+33 and sees the new value.
- Back-to-back mult: the second mult stalls identically and is accepted at edge N+33.
- `flush` together with `ex_stall`: bubble wins.
- Reset mid-RUN: state returns to IDLE, HI/LO=0, all `ex_*` outputs=0, `id_stall`=0, `mul_busy`=0 in the cycle after the reset edge.

## Test plan
- **add** 0x00221820 (rs=1, rt=2, rd=3) → `ex_func`=0010, `ex_imm_sel`=0, `ex_reg_write`=1, `ex_wr_reg`=3, `ex_valid`=1 one cycle later.
- **Immediates**
  - andi 0x3022FFFF → `ex_imm`=0x0000FFFF, `ex_func`=0000, `ex_wr_reg`=2.
  - addi 0x2022FFFF → `ex_imm`=0xFFFFFFFF, `ex_func`=0010.
  - lui 0x3C011234 → `ex_imm`=0x12340000, `ex_func`=0101.
- **Signed multiply**: mult with rs=0xFFFFFFF9 (−7), rt=3, followed by mfhi then mflo.
  - `id_stall` is high 32 cycles.
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - mfhi issues `ex_imm`=0xFFFFFFFF with `ex_func`=0101.
- **Unsigned multiply**: multu with the same operands → HI=0x00000002, LO=0xFFFFFFEB.
- **Priority and illegal**
  - `flush`=1 and `ex_stall`=1 in the same cycle → bubble.
  - `ex_stall` alone → `ex_*` held unchanged for 3 cycles.
  - Opcode 0x3F → `ex_illegal`=1, `ex_valid`=0.
- **Reset mid-multiply**: assert `rst_n`=0 at RUN step 10 → next cycle `mul_busy`=0, HI=LO=0, all `ex_*` outputs 0. A new mult after release completes normally in 32 cycles.

Source files
------------

// File: rtl/alu_issue.sv
// Decode-and-issue stage: decodes a MIPS instruction into the ID/EX register for the 4-bit ALU,
// and runs a 32-cycle shift-add multiplier that owns the HI/LO registers.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        id_stall,
  output logic        ex_valid,
  output logic [3:0]  ex_func,
  output logic        ex_imm_sel,
  output logic [31:0] ex_imm,
  output logic        ex_reg_write,
  output logic [4:0]  ex_wr_reg,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [1:0]  ex_branch,
  output logic        ex_illegal,
  output logic        mul_busy
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} mul_state_e;

  logic [5:0]  opcode_s, funct_s;
  logic [4:0]  rt_s, rd_s;
  logic [31:0] sext_s, zext_s;

  logic        dec_legal_s, dec_mult_s, dec_signed_s, dec_hilo_s;
  logic [3:0]  dec_func_s;
  logic        dec_imm_sel_s, dec_reg_write_s, dec_mem_read_s, dec_mem_write_s;
  logic [31:0] dec_imm_s;
  logic [4:0]  dec_wr_reg_s;
  logic [1:0]  dec_branch_s;

  logic [48:0] ex_q, ex_d;
  logic        load_mul_s;

  mul_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic        neg_q, neg_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [32:0] step_sum_s;
  logic [63:0] step_acc_s, prod_s;

  assign opcode_s = id_instr[31:26];
  assign funct_s  = id_instr[5:0];
  assign rt_s     = id_instr[20:16];
  assign rd_s     = id_instr[15:11];
  assign sext_s   = {{16{id_instr[15]}}, id_instr[15:0]};
  assign zext_s   = {16'h0000, id_instr[15:0]};

  // Instruction decode into ALU control, immediate and writeback/memory controls
  always_comb begin
    dec_legal_s     = 1'b0;
    dec_mult_s      = 1'b0;
    dec_signed_s    = 1'b0;
    dec_hilo_s      = 1'b0;
    dec_func_s      = 4'b0000;
    dec_imm_sel_s   = 1'b0;
    dec_imm_s       = 32'h0000_0000;
    dec_reg_write_s = 1'b0;
    dec_wr_reg_s    = 5'd0;
    dec_mem_read_s  = 1'b0;
    dec_mem_write_s = 1'b0;
    dec_branch_s    = 2'b00;
    if (opcode_s == 6'h00) begin
      dec_legal_s     = 1'b1;
      dec_reg_write_s = 1'b1;
      dec_wr_reg_s    = rd_s;
      case (funct_s)
        6'h20, 6'h21: dec_func_s = 4'b0010;
        6'h22, 6'h23: dec_func_s = 4'b1010;
        6'h24:        dec_func_s = 4'b0000;
        6'h25:        dec_func_s = 4'b0001;
        6'h26:        dec_func_s = 4'b0011;
        6'h2A, 6'h2B: dec_func_s = 4'b1111;
        6'h18, 6'h19: begin
          dec_mult_s      = 1'b1;
          dec_signed_s    = (funct_s == 6'h18);
          dec_reg_write_s = 1'b0;
          dec_wr_reg_s    = 5'd0;
        end
        6'h10, 6'h12: begin
          dec_hilo_s    = 1'b1;
          dec_func_s    = 4'b0101;
          dec_imm_sel_s = 1'b1;
          dec_imm_s     = (funct_s == 6'h10) ? hi_q : lo_q;
        end
        default: begin
          dec_legal_s     = 1'b0;
          dec_reg_write_s = 1'b0;
          dec_wr_reg_s    = 5'd0;
        end
      endcase
    end else begin
      dec_legal_s = 1'b1;
      case (opcode_s)
        6'h02: begin
          dec_func_s   = 4'b0010;
          dec_branch_s = 2'b11;
          dec_imm_s    = {6'd0, id_instr[25:0]};
        end
        6'h04, 6'h05: begin
          dec_func_s   = 4'b1010;
          dec_branch_s = (opcode_s == 6'h04) ? 2'b01 : 2'b10;
          dec_imm_s    = sext_s;
        end
        6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: begin
          dec_imm_sel_s   = 1'b1;
          dec_reg_write_s = 1'b1;
          dec_wr_reg_s    = rt_s;
          dec_mem_read_s  = (opcode_s == 6'h23);
          case (opcode_s)
            6'h0A, 6'h0B: begin dec_func_s = 4'b1111; dec_imm_s = sext_s; end
            6'h0C:        begin dec_func_s = 4'b0000; dec_imm_s = zext_s; end
            6'h0D:        begin dec_func_s = 4'b0001; dec_imm_s = zext_s; end
            6'h0E:        begin dec_func_s = 4'b0011; dec_imm_s = zext_s; end
            6'h0F:        begin dec_func_s = 4'b0101; dec_imm_s = {id_instr[15:0], 16'h0000}; end
            default:      begin dec_func_s = 4'b0010; dec_imm_s = sext_s; end
          endcase
        end
        6'h2B: begin
          dec_func_s      = 4'b0010;
          dec_imm_sel_s   = 1'b1;
          dec_imm_s       = sext_s;
          dec_mem_write_s = 1'b1;
        end
        default: dec_legal_s = 1'b0;
      endcase
    end
  end

  assign id_stall = id_valid & mul_busy & (dec_mult_s | dec_hilo_s);

  // ID/EX next-state: flush, then hold, then stall bubble, then load
  always_comb begin
    ex_d       = ex_q;
    load_mul_s = 1'b0;
    if (flush) begin
      ex_d = 49'd0;
    end else if (ex_stall) begin
      ex_d = ex_q;
    end else if (id_stall || !id_valid) begin
      ex_d = 49'd0;
    end else if (!dec_legal_s) begin
      ex_d = 49'd1;
    end else begin
      ex_d = {1'b1, dec_func_s, dec_imm_sel_s, dec_imm_s, dec_reg_write_s, dec_wr_reg_s,
              dec_mem_read_s, dec_mem_write_s, dec_branch_s, 1'b0};
      load_mul_s = dec_mult_s;
    end
  end

  // The low half of the accumulator starts as the multiplier and shifts out one bit per step
  assign step_sum_s = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign step_acc_s = {step_sum_s, acc_q[31:1]};
  assign prod_s     = neg_q ? (~step_acc_s + 64'd1) : step_acc_s;

  // Multiplier FSM next-state and HI/LO update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (load_mul_s) begin
          state_d = S_RUN;
          cnt_d   = 6'd0;
          mcand_d = (dec_signed_s && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
          acc_d   = {32'd0, (dec_signed_s && rt_val[31]) ? (~rt_val + 32'd1) : rt_val};
          neg_d   = dec_signed_s & (rs_val[31] ^ rt_val[31]);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = step_acc_s;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_IDLE;
          hi_d    = prod_s[63:32];
          lo_d    = prod_s[31:0];
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= 49'd0;
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      acc_q   <= 64'd0;
      mcand_q <= 32'd0;
      neg_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign {ex_valid, ex_func, ex_imm_sel, ex_imm, ex_reg_write, ex_wr_reg,
          ex_mem_read, ex_mem_write, ex_branch, ex_illegal} = ex_q;
  assign mul_busy = (state_q == S_RUN);

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus random traffic, checked against a
// mnemonic-level reference model with 64-bit arithmetic multiply and a cycle countdown.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, ex_stall, flush;
  logic [31:0] id_instr, rs_val, rt_val;
  logic        id_stall, ex_valid, ex_imm_sel, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_illegal, mul_busy;
  logic [3:0]  ex_func;
  logic [31:0] ex_imm;
  logic [4:0]  ex_wr_reg;
  logic [1:0]  ex_branch;

  int checks = 0;
  int failures = 0;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .rs_val(rs_val), .rt_val(rt_val), .ex_stall(ex_stall), .flush(flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_func(ex_func), .ex_imm_sel(ex_imm_sel),
    .ex_imm(ex_imm), .ex_reg_write(ex_reg_write), .ex_wr_reg(ex_wr_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_illegal(ex_illegal), .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  typedef enum int {M_ILL, M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLT, M_MULT, M_MULTU,
                    M_MFHI, M_MFLO, M_J, M_BEQ, M_BNE, M_ADDI, M_SLTI, M_ANDI, M_ORI,
                    M_XORI, M_LUI, M_LW, M_SW} mn_e;

  // Reference model state
  logic [48:0] m_ex = 49'd0;
  int          m_busy = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_ph = 32'd0, m_pl = 32'd0;
  logic        last_stall = 1'b0;

  logic [5:0] r_fn [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B,
                            6'h18, 6'h19, 6'h10, 6'h12};
  logic [5:0] i_op [13] = '{6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                            6'h0E, 6'h0F, 6'h23, 6'h2B};

  function automatic mn_e mnem(input logic [31:0] ins);
    mn_e m;
    m = M_ILL;
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h20, 6'h21: m = M_ADD;
        6'h22, 6'h23: m = M_SUB;
        6'h24: m = M_AND;
        6'h25: m = M_OR;
        6'h26: m = M_XOR;
        6'h2A, 6'h2B: m = M_SLT;
        6'h18: m = M_MULT;
        6'h19: m = M_MULTU;
        6'h10: m = M_MFHI;
        6'h12: m = M_MFLO;
        default: m = M_ILL;
      endcase
    end else begin
      case (ins[31:26])
        6'h02: m = M_J;
        6'h04: m = M_BEQ;
        6'h05: m = M_BNE;
        6'h08, 6'h09: m = M_ADDI;
        6'h0A, 6'h0B: m = M_SLTI;
        6'h0C: m = M_ANDI;
        6'h0D: m = M_ORI;
        6'h0E: m = M_XORI;
        6'h0F: m = M_LUI;
        6'h23: m = M_LW;
        6'h2B: m = M_SW;
        default: m = M_ILL;
      endcase
    end
    return m;
  endfunction

  function automatic logic [3:0] alu_code(input mn_e m);
    case (m)
      M_AND, M_ANDI, M_MULT, M_MULTU: return 4'b0000;
      M_OR, M_ORI:                    return 4'b0001;
      M_XOR, M_XORI:                  return 4'b0011;
      M_LUI, M_MFHI, M_MFLO:          return 4'b0101;
      M_SUB, M_BEQ, M_BNE:            return 4'b1010;
      M_SLT, M_SLTI:                  return 4'b1111;
      default:                        return 4'b0010;
    endcase
  endfunction

  // Expected ID/EX contents for a legal instruction, in the DUT output order
  function automatic logic [48:0] ref_decode(input logic [31:0] ins, input logic [31:0] hi,
                                             input logic [31:0] lo);
    mn_e m; logic isel, rw, mr, mw; logic [31:0] imm; logic [4:0] wr; logic [1:0] br;
    logic [31:0] sx, zx;
    m = mnem(ins);
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    isel = 1'b0; rw = 1'b0; mr = 1'b0; mw = 1'b0; imm = 32'd0; wr = 5'd0; br = 2'b00;
    case (m)
      M_ILL: return 49'd1;
      M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLT: begin rw = 1'b1; wr = ins[15:11]; end
      M_MFHI: begin isel = 1'b1; imm = hi; rw = 1'b1; wr = ins[15:11]; end
      M_MFLO: begin isel = 1'b1; imm = lo; rw = 1'b1; wr = ins[15:11]; end
      M_J:    begin br = 2'b11; imm = {6'd0, ins[25:0]}; end
      M_BEQ:  begin br = 2'b01; imm = sx; end
      M_BNE:  begin br = 2'b10; imm = sx; end
      M_ADDI, M_SLTI: begin isel = 1'b1; imm = sx; rw = 1'b1; wr = ins[20:16]; end
      M_ANDI, M_ORI, M_XORI: begin isel = 1'b1; imm = zx; rw = 1'b1; wr = ins[20:16]; end
      M_LUI:  begin isel = 1'b1; imm = {ins[15:0], 16'h0}; rw = 1'b1; wr = ins[20:16]; end
      M_LW:   begin isel = 1'b1; imm = sx; rw = 1'b1; wr = ins[20:16]; mr = 1'b1; end
      M_SW:   begin isel = 1'b1; imm = sx; mw = 1'b1; end
      default: ;
    endcase
    return {1'b1, alu_code(m), isel, imm, rw, wr, mr, mw, br, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model across one rising edge using the current inputs
  task automatic model_edge(input logic stall);
    mn_e m;
    logic [63:0] p;
    logic [48:0] dec;
    if (!rst_n) begin
      m_ex = 49'd0; m_busy = 0; m_hi = 32'd0; m_lo = 32'd0;
      return;
    end
    m = mnem(id_instr);
    dec = ref_decode(id_instr, m_hi, m_lo);
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin m_hi = m_ph; m_lo = m_pl; end
    end
    if (flush) m_ex = 49'd0;
    else if (ex_stall) m_ex = m_ex;
    else if (stall || !id_valid) m_ex = 49'd0;
    else begin
      m_ex = dec;
      if (m == M_MULT || m == M_MULTU) begin
        if (m == M_MULT) p = 64'(longint'($signed(rs_val)) * longint'($signed(rt_val)));
        else             p = {32'd0, rs_val} * {32'd0, rt_val};
        m_ph = p[63:32]; m_pl = p[31:0]; m_busy = 32;
      end
    end
  endtask

  task automatic tick();
    logic exp_st; mn_e m;
    #1;
    m = mnem(id_instr);
    exp_st = id_valid && (m_busy > 0) && (m inside {M_MULT, M_MULTU, M_MFHI, M_MFLO});
    chk("id_stall", 64'(id_stall), 64'(exp_st));
    last_stall = exp_st;
    model_edge(exp_st);
    @(posedge clk);
    @(negedge clk);
    chk("ex_bus", 64'({ex_valid, ex_func, ex_imm_sel, ex_imm, ex_reg_write, ex_wr_reg,
                       ex_mem_read, ex_mem_write, ex_branch, ex_illegal}), 64'(m_ex));
    chk("mul_busy", 64'(mul_busy), (m_busy > 0) ? 64'd1 : 64'd0);
  endtask

  task automatic issue(input logic [31:0] ins);
    id_valid = 1'b1; id_instr = ins; flush = 1'b0; ex_stall = 1'b0;
    tick();
    id_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int sel;
    ins = $urandom;
    sel = $urandom_range(0, 9);
    if (sel >= 1 && sel <= 5) begin
      ins[31:26] = 6'h00;
      ins[5:0] = r_fn[$urandom_range(0, 12)];
    end else if (sel >= 6) begin
      ins[31:26] = i_op[$urandom_range(0, 12)];
    end
    return ins;
  endfunction

  initial begin
    int n;
    rst_n = 1'b0; id_valid = 1'b0; id_instr = 32'd0; rs_val = 32'd0; rt_val = 32'd0;
    ex_stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    tick(); tick();
    chk("reset_valid", 64'(ex_valid), 64'd0);
    rst_n = 1'b1;

    issue(32'h00221820);
    chk("add_func", 64'(ex_func), 64'h2);
    chk("add_wr", 64'({ex_valid, ex_imm_sel, ex_reg_write, ex_wr_reg}), 64'({3'b101, 5'd3}));
    issue(32'h3022FFFF);
    chk("andi_imm", 64'({ex_func, ex_imm, ex_wr_reg}), 64'({4'b0000, 32'h0000FFFF, 5'd2}));
    issue(32'h2022FFFF);
    chk("addi_imm", 64'({ex_func, ex_imm}), 64'({4'b0010, 32'hFFFFFFFF}));
    issue(32'h3C011234);
    chk("lui_imm", 64'({ex_func, ex_imm}), 64'({4'b0101, 32'h12340000}));

    // Signed then unsigned multiply, each followed by a stalled mfhi and an mflo
    for (int k = 0; k < 2; k++) begin
      rs_val = 32'hFFFFFFF9; rt_val = 32'd3;
      issue((k == 0) ? 32'h00220018 : 32'h00220019);
      id_valid = 1'b1; id_instr = 32'h00002010;
      n = 0;
      for (int g = 0; g < 40; g++) begin
        #1;
        if (!id_stall) break;
        tick();
        n++;
      end
      chk("stall_cycles", 64'(n), 64'd32);
      tick();
      chk("mfhi_val", 64'({ex_func, ex_imm}),
          64'({4'b0101, (k == 0) ? 32'hFFFFFFFF : 32'h00000002}));
      issue(32'h00002812);
      chk("mflo_val", 64'(ex_imm), 64'hFFFFFFEB);
    end

    issue(32'h00221820);
    id_valid = 1'b1; id_instr = 32'h3022FFFF; flush = 1'b1; ex_stall = 1'b1;
    tick();
    chk("flush_wins", 64'({ex_valid, ex_reg_write}), 64'd0);
    issue(32'h3C011234);
    id_valid = 1'b1; id_instr = 32'h2022FFFF; ex_stall = 1'b1;
    for (int h = 0; h < 3; h++) begin
      tick();
      chk("hold_lui", 64'({ex_valid, ex_imm}), 64'({1'b1, 32'h12340000}));
    end
    issue(32'hFC000000);
    chk("illegal", 64'({ex_illegal, ex_valid, ex_reg_write}), 64'({3'b100}));

    // Reset partway through a multiply, then a fresh multiply
    rs_val = 32'hFFFFFFF9; rt_val = 32'd3;
    issue(32'h00220018);
    for (int s = 0; s < 9; s++) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_busy", 64'(mul_busy), 64'd0);
    rst_n = 1'b1;
    issue(32'h00002010);
    chk("rst_hi", 64'(ex_imm), 64'd0);
    issue(32'h00002812);
    chk("rst_lo", 64'(ex_imm), 64'd0);
    rs_val = 32'd5; rt_val = 32'd6;
    issue(32'h00220019);
    n = 0;
    while (mul_busy && n < 40) begin tick(); n++; end
    chk("busy_cycles", 64'(n), 64'd32);
    issue(32'h00002812);
    chk("mflo_30", 64'(ex_imm), 64'd30);

    for (int i = 0; i < 500; i++) begin
      if (!last_stall) id_instr = rand_instr();
      id_valid = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 15) == 0);
      ex_stall = ($urandom_range(0, 9) == 0);
      rs_val = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 100));
      rt_val = $urandom;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
